// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one ALU between two requesters.
// Each accepted op is latched, issued to the ALU for one cycle, and the
// captured result is returned on a response channel tagged with the requester id.
module alu_arbiter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [2:0]   req0_func,
  input  logic [W-1:0] req0_a,
  input  logic [W-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [2:0]   req1_func,
  input  logic [W-1:0] req1_a,
  input  logic [W-1:0] req1_b,
  output logic [2:0]   alu_func,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_sum,
  input  logic         alu_cout,
  input  logic         alu_overflow,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_cout,
  output logic         rsp_overflow,
  output logic         rsp_zero,
  output logic         busy,
  output logic [7:0]   ops_done
);

  localparam int unsigned FUNC_W = 3;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_ptr;
  logic [FUNC_W-1:0]   r_func;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic                r_id;
  logic [W-1:0]        r_rsp_result;
  logic                r_rsp_cout;
  logic                r_rsp_overflow;
  logic                r_rsp_zero;
  logic [CNT_W-1:0]    r_ops_done;

  logic                w_any;
  logic                w_gnt_id;
  logic                w_accept;
  logic                w_rsp_hs;

  // Tie goes to the pointer; a lone valid always wins.
  assign w_any    = req0_valid | req1_valid;
  assign w_gnt_id = (req0_valid & req1_valid) ? r_ptr : req1_valid;
  assign w_accept = (r_state == ST_IDLE) & w_any;
  assign w_rsp_hs = (r_state == ST_RESP) & rsp_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_next = ST_ISSUE;
      ST_ISSUE: w_next = ST_RESP;
      ST_RESP:  if (rsp_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Per-state handshake and status outputs.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (r_state)
      ST_IDLE: begin
        busy       = 1'b0;
        req0_ready = w_any & ~w_gnt_id;
        req1_ready = w_any & w_gnt_id;
      end
      ST_RESP:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand latch and round-robin pointer update on request handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_func <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_id   <= 1'b0;
      r_ptr  <= 1'b0;
    end else if (w_accept) begin
      r_func <= w_gnt_id ? req1_func : req0_func;
      r_a    <= w_gnt_id ? req1_a    : req0_a;
      r_b    <= w_gnt_id ? req1_b    : req0_b;
      r_id   <= w_gnt_id;
      r_ptr  <= ~w_gnt_id;
    end
  end

  // Capture ALU result and flags during the issue cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_result   <= '0;
      r_rsp_cout     <= 1'b0;
      r_rsp_overflow <= 1'b0;
      r_rsp_zero     <= 1'b0;
    end else if (r_state == ST_ISSUE) begin
      r_rsp_result   <= alu_sum;
      r_rsp_cout     <= alu_cout;
      r_rsp_overflow <= alu_overflow;
      r_rsp_zero     <= (alu_sum == '0);
    end
  end

  // Completed-response counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_ops_done <= '0;
    else if (w_rsp_hs) r_ops_done <= r_ops_done + CNT_W'(1);
  end

  assign alu_func     = r_func;
  assign alu_a        = r_a;
  assign alu_b        = r_b;
  assign rsp_id       = r_id;
  assign rsp_result   = r_rsp_result;
  assign rsp_cout     = r_rsp_cout;
  assign rsp_overflow = r_rsp_overflow;
  assign rsp_zero     = r_rsp_zero;
  assign ops_done     = r_ops_done;

endmodule
